// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the parametrised serial-MAC FIR.
// round_shift and saturate work on a wide signed container so callers only sign-extend in and slice out.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } firState_t;

    localparam int MAX_W = 64;

    function automatic int accWidth(input int dataW, input int coefW, input int ntaps);
        return dataW + coefW + $clog2(ntaps);
    endfunction

    function automatic logic signed [MAX_W-1:0] round_shift(
        input logic signed [MAX_W-1:0] v,
        input int                      sh
    );
        logic signed [MAX_W-1:0] one;
        logic signed [MAX_W-1:0] r;
        one = 64'sd1;
        if (sh > 0) begin
            r = (v + (one <<< (sh - 1))) >>> sh;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic signed [MAX_W-1:0] saturate(
        input logic signed [MAX_W-1:0] v,
        input int                      w
    );
        logic signed [MAX_W-1:0] one;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        logic signed [MAX_W-1:0] r;
        one = 64'sd1;
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_coef_regs.sv
// Coefficient register file: gated write port (ignored while the filter is busy),
// combinational read by tap index, synchronous clear.
module fir_coef_regs
    import fir_pkg::*;
#(
    parameter int NTAPS  = 16,
    parameter int COEF_W = 10,
    parameter int AW     = $clog2(NTAPS)
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iBusy,
    input  logic                     iWe,
    input  logic [AW-1:0]            iAddr,
    input  logic signed [COEF_W-1:0] iData,
    input  logic [AW-1:0]            iRdAddr,
    output logic signed [COEF_W-1:0] oRdData
);

    logic signed [COEF_W-1:0] coefR [NTAPS];

    // Coefficient storage with write gating
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < NTAPS; i++) begin
                coefR[i] <= {COEF_W{1'b0}};
            end
        end else if (iWe && !iBusy && (int'(iAddr) < NTAPS)) begin
            coefR[iAddr] <= iData;
        end
    end

    assign oRdData = coefR[iRdAddr];

endmodule

// File: rtl/fir_filter_param.sv
// Serial-MAC FIR: one strobed sample in, NTAPS multiply-accumulate cycles,
// then a rounded, scaled and saturated output with a one-cycle valid pulse.
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int COEF_W = 10,
    parameter int NTAPS  = 16,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic                        iEnSample,
    input  logic signed [DATA_W-1:0]    iFirIn,
    input  logic                        iCoefWe,
    input  logic [$clog2(NTAPS)-1:0]    iCoefAddr,
    input  logic signed [COEF_W-1:0]    iCoefData,
    input  logic                        iClrOvr,
    output logic signed [OUT_W-1:0]     oFirOut,
    output logic                        oFirValid,
    output logic                        oBusy,
    output logic                        oOverrun
);

    localparam int              ACC_W  = accWidth(DATA_W, COEF_W, NTAPS);
    localparam int              KW     = $clog2(NTAPS);
    localparam logic [KW-1:0]   LAST_K = KW'(NTAPS - 1);
    localparam logic [KW-1:0]   K_ONE  = KW'(32'd1);

    firState_t                stateR;
    firState_t                nextStateS;
    logic                     busyR;
    logic [KW-1:0]            kR;
    logic signed [ACC_W-1:0]  accR;
    logic signed [ACC_W-1:0]  prodS;
    logic signed [DATA_W-1:0] xR [NTAPS];
    logic signed [COEF_W-1:0] coefRdS;
    logic signed [MAX_W-1:0]  satWideS;
    logic signed [OUT_W-1:0]  satOutS;
    logic signed [OUT_W-1:0]  firOutR;
    logic                     validR;
    logic                     overrunR;
    logic                     acceptS;
    logic                     dropS;

    fir_coef_regs #(
        .NTAPS  (NTAPS),
        .COEF_W (COEF_W),
        .AW     (KW)
    ) uCoefRegs (
        .iClk    (iClk),
        .iRst    (iRst),
        .iBusy   (busyR),
        .iWe     (iCoefWe),
        .iAddr   (iCoefAddr),
        .iData   (iCoefData),
        .iRdAddr (kR),
        .oRdData (coefRdS)
    );

    // State register; busy tracks the state being entered so it is a plain flop output
    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateR <= IDLE;
            busyR  <= 1'b0;
        end else begin
            stateR <= nextStateS;
            busyR  <= (nextStateS != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        nextStateS = stateR;
        case (stateR)
            IDLE: begin
                if (iEnSample) begin
                    nextStateS = MAC;
                end else begin
                    nextStateS = IDLE;
                end
            end
            MAC: begin
                if (kR == LAST_K) begin
                    nextStateS = OUT;
                end else begin
                    nextStateS = MAC;
                end
            end
            OUT:     nextStateS = IDLE;
            default: nextStateS = IDLE;
        endcase
    end

    // Strobe classification, tap product and output conditioning
    always_comb begin
        acceptS  = iEnSample && !busyR;
        dropS    = iEnSample && busyR;
        prodS    = ACC_W'(xR[kR]) * ACC_W'(coefRdS);
        satWideS = saturate(round_shift(MAX_W'(accR), SHIFT), OUT_W);
        satOutS  = satWideS[OUT_W-1:0];
    end

    // Delay line, accumulator, tap index and output register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            accR    <= {ACC_W{1'b0}};
            kR      <= {KW{1'b0}};
            firOutR <= {OUT_W{1'b0}};
            validR  <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                xR[i] <= {DATA_W{1'b0}};
            end
        end else begin
            validR <= 1'b0;
            case (stateR)
                IDLE: begin
                    if (acceptS) begin
                        for (int i = NTAPS - 1; i > 0; i--) begin
                            xR[i] <= xR[i-1];
                        end
                        xR[0] <= iFirIn;
                        accR  <= {ACC_W{1'b0}};
                        kR    <= {KW{1'b0}};
                    end
                end
                MAC: begin
                    accR <= accR + prodS;
                    kR   <= kR + K_ONE;
                end
                OUT: begin
                    firOutR <= satOutS;
                    validR  <= 1'b1;
                end
                default: begin
                    validR <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun flag; a new drop wins over a simultaneous clear
    always_ff @(posedge iClk) begin
        if (iRst) begin
            overrunR <= 1'b0;
        end else if (dropS) begin
            overrunR <= 1'b1;
        end else if (iClrOvr) begin
            overrunR <= 1'b0;
        end
    end

    assign oFirOut   = firOutR;
    assign oFirValid = validR;
    assign oBusy     = busyR;
    assign oOverrun  = overrunR;

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed bench for fir_filter_param: default, 8-bit-output and SHIFT=2 instances share stimulus.
module tb_fir_filter_param;

    logic              iClk = 1'b0;
    logic              iRst;
    logic              iEnSample;
    logic signed [2:0] iFirIn;
    logic              iCoefWe;
    logic [3:0]        iCoefAddr;
    logic signed [9:0] iCoefData;
    logic              iClrOvr;

    logic signed [15:0] outA;
    logic               validA, busyA, ovrA;
    logic signed [7:0]  outB;
    logic               validB, busyB, ovrB;
    logic signed [15:0] outC;
    logic               validC, busyC, ovrC;

    int checks = 0;
    int errors = 0;

    always #5 iClk = ~iClk;

    fir_filter_param dutA (
        .iClk(iClk), .iRst(iRst), .iEnSample(iEnSample), .iFirIn(iFirIn),
        .iCoefWe(iCoefWe), .iCoefAddr(iCoefAddr), .iCoefData(iCoefData), .iClrOvr(iClrOvr),
        .oFirOut(outA), .oFirValid(validA), .oBusy(busyA), .oOverrun(ovrA)
    );

    fir_filter_param #(.OUT_W(8)) dutB (
        .iClk(iClk), .iRst(iRst), .iEnSample(iEnSample), .iFirIn(iFirIn),
        .iCoefWe(iCoefWe), .iCoefAddr(iCoefAddr), .iCoefData(iCoefData), .iClrOvr(iClrOvr),
        .oFirOut(outB), .oFirValid(validB), .oBusy(busyB), .oOverrun(ovrB)
    );

    fir_filter_param #(.SHIFT(2)) dutC (
        .iClk(iClk), .iRst(iRst), .iEnSample(iEnSample), .iFirIn(iFirIn),
        .iCoefWe(iCoefWe), .iCoefAddr(iCoefAddr), .iCoefData(iCoefData), .iClrOvr(iClrOvr),
        .oFirOut(outC), .oFirValid(validC), .oBusy(busyC), .oOverrun(ovrC)
    );

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic doReset();
        iRst = 1'b1;
        tick();
        tick();
        iRst = 1'b0;
    endtask

    task automatic writeCoef(input int addr, input logic signed [9:0] data);
        iCoefWe   = 1'b1;
        iCoefAddr = 4'(addr);
        iCoefData = data;
        tick();
        iCoefWe   = 1'b0;
    endtask

    task automatic writeRamp();
        for (int k = 0; k < 16; k++) writeCoef(k, 10'(k + 1));
    endtask

    task automatic writeAll(input logic signed [9:0] data);
        for (int k = 0; k < 16; k++) writeCoef(k, data);
    endtask

    // Leaves the caller just after the edge that sampled the strobe (E0)
    task automatic strobe(input logic signed [2:0] s);
        iEnSample = 1'b1;
        iFirIn    = s;
        tick();
        iEnSample = 1'b0;
    endtask

    // Bounded wait for the selected instance's valid pulse; lat = 0 means it never came
    task automatic waitValid(input int which, output int lat, output int val);
        logic v;
        lat = 0;
        val = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            case (which)
                1:       v = validB;
                2:       v = validC;
                default: v = validA;
            endcase
            if (v) begin
                lat = c;
                case (which)
                    1:       val = int'(outB);
                    2:       val = int'(outC);
                    default: val = int'(outA);
                endcase
                break;
            end
        end
    endtask

    task automatic test_reset();
        iRst = 1'b1; iEnSample = 1'b0; iFirIn = 3'b000; iCoefWe = 1'b0;
        iCoefAddr = 4'd0; iCoefData = 10'sd0; iClrOvr = 1'b0;
        tick();
        tick();
        checks++; if (outA !== 16'sd0) begin errors++; $display("FAIL reset_outA got %0d expected 0", outA); end
        checks++; if ({validA, busyA, ovrA} !== 3'b000) begin errors++; $display("FAIL reset_flagsA got %b expected 000", {validA, busyA, ovrA}); end
        checks++; if ({outB, validB, busyB, ovrB} !== 11'd0) begin errors++; $display("FAIL reset_B got %h expected 0", {outB, validB, busyB, ovrB}); end
        checks++; if ({outC, validC, busyC, ovrC} !== 19'd0) begin errors++; $display("FAIL reset_C got %h expected 0", {outC, validC, busyC, ovrC}); end
        iRst = 1'b0;
    endtask

    task automatic test_impulse();
        int lat, val;
        doReset();
        writeRamp();
        strobe(3'b111);
        waitValid(0, lat, val);
        checks++; if (lat !== 17) begin errors++; $display("FAIL impulse_latency got %0d expected 17", lat); end
        checks++; if (val !== -1) begin errors++; $display("FAIL impulse_1 got %0d expected -1", val); end
        for (int n = 2; n <= 17; n++) begin
            strobe(3'b000);
            waitValid(0, lat, val);
            checks++; if (lat !== 17) begin errors++; $display("FAIL impulse_lat_%0d got %0d expected 17", n, lat); end
            checks++; if (val !== ((n <= 16) ? -n : 0)) begin errors++; $display("FAIL impulse_%0d got %0d expected %0d", n, val, (n <= 16) ? -n : 0); end
        end
    endtask

    task automatic test_step();
        int lat, val;
        doReset();
        writeAll(10'sd10);
        for (int n = 1; n <= 18; n++) begin
            strobe(3'sd3);
            waitValid(0, lat, val);
            checks++; if (val !== ((n <= 16) ? 30 * n : 480)) begin errors++; $display("FAIL step_%0d got %0d expected %0d", n, val, (n <= 16) ? 30 * n : 480); end
        end
    endtask

    task automatic test_saturation();
        int lat, val;
        doReset();
        writeAll(10'sd511);
        strobe(3'sd3);
        waitValid(1, lat, val);
        checks++; if (val !== 127) begin errors++; $display("FAIL sat_pos got %0d expected 127", val); end
        checks++; if (int'(outA) !== 1533) begin errors++; $display("FAIL sat_pos_wide got %0d expected 1533", outA); end
        strobe(3'b100);
        waitValid(1, lat, val);
        checks++; if (val !== -128) begin errors++; $display("FAIL sat_neg got %0d expected -128", val); end
        checks++; if (int'(outA) !== -511) begin errors++; $display("FAIL sat_neg_wide got %0d expected -511", outA); end
    endtask

    task automatic test_rounding();
        int lat, val;
        doReset();
        writeCoef(0, 10'sd2);
        strobe(3'sd3);
        waitValid(2, lat, val);
        checks++; if (val !== 2) begin errors++; $display("FAIL round_p6 got %0d expected 2", val); end
        checks++; if (int'(outA) !== 6) begin errors++; $display("FAIL round_p6_raw got %0d expected 6", outA); end
        strobe(3'b101);
        waitValid(2, lat, val);
        checks++; if (val !== -1) begin errors++; $display("FAIL round_m6 got %0d expected -1", val); end
        checks++; if (int'(outA) !== -6) begin errors++; $display("FAIL round_m6_raw got %0d expected -6", outA); end
        writeCoef(0, 10'sd5);
        strobe(3'sd1);
        waitValid(2, lat, val);
        checks++; if (val !== 1) begin errors++; $display("FAIL round_p5 got %0d expected 1", val); end
    endtask

    task automatic test_overrun();
        int lat, val, nValid;
        doReset();
        writeRamp();
        strobe(3'sd1);
        for (int i = 0; i < 4; i++) tick();
        checks++; if (ovrA !== 1'b0) begin errors++; $display("FAIL ovr_before got %b expected 0", ovrA); end
        iEnSample = 1'b1; iFirIn = 3'b111;
        tick();
        iEnSample = 1'b0;
        checks++; if (ovrA !== 1'b1) begin errors++; $display("FAIL ovr_set got %b expected 1", ovrA); end
        nValid = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (validA) begin nValid++; val = int'(outA); end
        end
        checks++; if (nValid !== 1) begin errors++; $display("FAIL ovr_valid_count got %0d expected 1", nValid); end
        checks++; if (val !== 1) begin errors++; $display("FAIL ovr_first got %0d expected 1", val); end
        strobe(3'b000);
        waitValid(0, lat, val);
        checks++; if (val !== 2) begin errors++; $display("FAIL ovr_delayline got %0d expected 2", val); end
        iClrOvr = 1'b1;
        tick();
        iClrOvr = 1'b0;
        checks++; if (ovrA !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b expected 0", ovrA); end
        strobe(3'b000);
        for (int i = 0; i < 16; i++) tick();
        iEnSample = 1'b1; iClrOvr = 1'b1; iFirIn = 3'b000;
        tick();
        iEnSample = 1'b0; iClrOvr = 1'b0;
        checks++; if (validA !== 1'b1 || int'(outA) !== 3) begin errors++; $display("FAIL ovr_out_cycle got valid=%b out=%0d expected valid=1 out=3", validA, outA); end
        checks++; if (ovrA !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b expected 1", ovrA); end
        strobe(3'b000);
        waitValid(0, lat, val);
        checks++; if (val !== 4) begin errors++; $display("FAIL ovr_out_drop got %0d expected 4", val); end
    endtask

    task automatic test_reset_mid_mac();
        int lat, val, nValid;
        doReset();
        writeRamp();
        strobe(3'sd1);
        waitValid(0, lat, val);
        checks++; if (val !== 1) begin errors++; $display("FAIL rst_pre got %0d expected 1", val); end
        strobe(3'sd1);
        for (int i = 0; i < 7; i++) tick();
        iRst = 1'b1;
        tick();
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", busyA); end
        checks++; if (outA !== 16'sd0) begin errors++; $display("FAIL rst_out got %0d expected 0", outA); end
        checks++; if (validA !== 1'b0) begin errors++; $display("FAIL rst_valid got %b expected 0", validA); end
        iRst = 1'b0;
        nValid = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (validA) nValid++;
        end
        checks++; if (nValid !== 0) begin errors++; $display("FAIL rst_no_valid got %0d expected 0", nValid); end
        writeRamp();
        strobe(3'b111);
        waitValid(0, lat, val);
        checks++; if (val !== -1) begin errors++; $display("FAIL rst_fresh got %0d expected -1", val); end
    endtask

    task automatic test_coef_busy();
        int lat, val;
        doReset();
        writeRamp();
        strobe(3'sd1);
        for (int i = 0; i < 3; i++) tick();
        writeCoef(0, 10'sd100);
        waitValid(0, lat, val);
        checks++; if (val !== 1) begin errors++; $display("FAIL coef_busy got %0d expected 1", val); end
        writeCoef(0, 10'sd100);
        strobe(3'sd1);
        waitValid(0, lat, val);
        checks++; if (val !== 102) begin errors++; $display("FAIL coef_idle got %0d expected 102", val); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_step();
        test_saturation();
        test_rounding();
        test_overrun();
        test_reset_mid_mac();
        test_coef_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
